// File: rtl/exc_fetch_ctrl_if.sv
// Fetch-stage exception unit bus: fetch request and stall/flush controls
// going in, registered F/D exception fields and debug status coming out.
interface exc_fetch_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int EXC_W  = 5,
   parameter int CNT_W  = 8
);
   // Fetch side and pipeline controls
   logic [ADDR_W-1:0] InstrAddr;
   logic              Fetch_Valid;
   logic              Stall_F;
   logic              Flush;

   // F/D register contents and debug status
   logic [EXC_W-1:0]  ExcCode_D;
   logic              AdEL_D;
   logic [ADDR_W-1:0] BadVAddr_D;
   logic              Valid_D;
   logic              ExcPending;
   logic [CNT_W-1:0]  ExcCount;

   // Pipeline side: drives the fetch request, observes the D-stage result
   modport master (
      output InstrAddr, Fetch_Valid, Stall_F, Flush,
      input  ExcCode_D, AdEL_D, BadVAddr_D, Valid_D, ExcPending, ExcCount
   );

   // Exception unit side
   modport slave (
      input  InstrAddr, Fetch_Valid, Stall_F, Flush,
      output ExcCode_D, AdEL_D, BadVAddr_D, Valid_D, ExcPending, ExcCount
   );
endinterface

// File: rtl/exc_fetch_ctrl.sv
// Fetch-stage exception unit.
// Flags misaligned or out-of-region fetch addresses, registers the result
// into the F/D boundary, and latches the first accepted fault until the
// pipe is flushed so that younger wrong-path fetches cannot replace it.
module exc_fetch_ctrl #(
   parameter int                ADDR_W     = 32,
   parameter int                ALIGN_BITS = 2,
   parameter logic [ADDR_W-1:0] R0_START   = ADDR_W'(32'h0000_3000),
   parameter logic [ADDR_W-1:0] R0_END     = ADDR_W'(32'h0000_6FFC),
   parameter bit                R1_EN      = 1'b0,
   parameter logic [ADDR_W-1:0] R1_START   = ADDR_W'(32'h0000_4180),
   parameter logic [ADDR_W-1:0] R1_END     = ADDR_W'(32'h0000_4FFC),
   parameter int                EXC_W      = 5,
   parameter logic [EXC_W-1:0]  EXC_ADEL   = EXC_W'(5'd4),
   parameter logic [EXC_W-1:0]  EXC_NONE   = EXC_W'(5'd0),
   parameter int                CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   exc_fetch_ctrl_if.slave  bus
);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t            r_state;
   logic [EXC_W-1:0]  r_exc_code;
   logic              r_adel;
   logic [ADDR_W-1:0] r_bad_vaddr;
   logic              r_valid;
   logic [CNT_W-1:0]  r_exc_count;

   logic              w_mis;
   logic              w_in0;
   logic              w_in1;
   logic              w_err;
   logic              w_err_acc;

   // Alignment check vanishes entirely when no low bits are constrained
   generate
      if (ALIGN_BITS > 0) begin : gen_align
         assign w_mis = |bus.InstrAddr[ALIGN_BITS-1:0];
      end else begin : gen_no_align
         assign w_mis = 1'b0;
      end
   endgenerate

   // Region membership, inclusive bounds, unsigned compare
   assign w_in0 = (bus.InstrAddr >= R0_START) && (bus.InstrAddr <= R0_END);

   generate
      if (R1_EN) begin : gen_r1
         assign w_in1 = (bus.InstrAddr >= R1_START) && (bus.InstrAddr <= R1_END);
      end else begin : gen_no_r1
         assign w_in1 = 1'b0;
      end
   endgenerate

   // Raw fault on a real fetch; masked while an older fault is outstanding
   assign w_err     = bus.Fetch_Valid & (w_mis | ~(w_in0 | w_in1));
   assign w_err_acc = w_err & (r_state == RUN);

   // F/D register, pending-fault FSM and debug counter (flush > stall > load)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= RUN;
         r_exc_code  <= EXC_NONE;
         r_adel      <= 1'b0;
         r_bad_vaddr <= '0;
         r_valid     <= 1'b0;
         r_exc_count <= '0;
      end else if (bus.Flush) begin
         // Exception entry / ERET: drop whatever is in D, re-arm detection.
         // The counter is debug history and deliberately survives.
         r_state     <= RUN;
         r_exc_code  <= EXC_NONE;
         r_adel      <= 1'b0;
         r_bad_vaddr <= '0;
         r_valid     <= 1'b0;
      end else if (!bus.Stall_F) begin
         r_valid    <= bus.Fetch_Valid;
         r_adel     <= w_err_acc;
         r_exc_code <= w_err_acc ? EXC_ADEL : EXC_NONE;
         if (w_err_acc) begin
            // BadVAddr keeps the last fault otherwise, for post-mortem reads
            r_bad_vaddr <= bus.InstrAddr;
            r_state     <= PEND;
            if (r_exc_count != CNT_MAX) begin
               r_exc_count <= r_exc_count + 1'b1;
            end
         end
      end
   end

   assign bus.ExcCode_D  = r_exc_code;
   assign bus.AdEL_D     = r_adel;
   assign bus.BadVAddr_D = r_bad_vaddr;
   assign bus.Valid_D    = r_valid;
   assign bus.ExcPending = (r_state == PEND);
   assign bus.ExcCount   = r_exc_count;

endmodule

// File: tb/tb_exc_fetch_ctrl.sv
// Bench for exc_fetch_ctrl: two instances (default parameters, and a
// two-region / 2-bit-counter variant) share stimulus; a rule-level model
// predicts every D-stage output each cycle.
module tb_exc_fetch_ctrl;

   logic clk;
   logic reset;

   exc_fetch_ctrl_if #(.ADDR_W(32), .EXC_W(5), .CNT_W(8)) bus0 ();
   exc_fetch_ctrl_if #(.ADDR_W(32), .EXC_W(5), .CNT_W(2)) bus1 ();

   exc_fetch_ctrl dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0.slave)
   );

   exc_fetch_ctrl #(
      .R0_END (32'h0000_3FFC),
      .R1_EN  (1'b1),
      .CNT_W  (2)
   ) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Model state per instance
   bit          m_pend  [2];
   int          m_cnt   [2];
   bit          m_valid [2];
   bit          m_adel  [2];
   int          m_code  [2];
   logic [31:0] m_bad   [2];

   // Per-instance configuration as seen by the model
   logic [31:0] c_r0e   [2];
   bit          c_r1en  [2];
   int          c_cmax  [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_is_err(input int d, input logic [31:0] a, input bit fv);
      bit in0;
      bit in1;
      in0 = (a >= 32'h0000_3000) && (a <= c_r0e[d]);
      in1 = c_r1en[d] && (a >= 32'h0000_4180) && (a <= 32'h0000_4FFC);
      return fv && ((a % 4) != 0 || !(in0 || in1));
   endfunction

   task automatic m_reset();
      for (int d = 0; d < 2; d++) begin
         m_pend[d] = 0; m_cnt[d] = 0; m_valid[d] = 0;
         m_adel[d] = 0; m_code[d] = 0; m_bad[d] = '0;
      end
   endtask

   task automatic m_clock(input logic [31:0] a, input bit fv, input bit st, input bit fl);
      bit acc;
      for (int d = 0; d < 2; d++) begin
         if (fl) begin
            m_valid[d] = 0; m_adel[d] = 0; m_code[d] = 0; m_bad[d] = '0; m_pend[d] = 0;
         end else if (!st) begin
            acc = m_is_err(d, a, fv) && !m_pend[d];
            m_valid[d] = fv;
            m_adel[d]  = acc;
            m_code[d]  = acc ? 4 : 0;
            if (acc) begin
               m_bad[d]  = a;
               m_pend[d] = 1;
               if (m_cnt[d] < c_cmax[d]) m_cnt[d]++;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("d0.Valid_D",    64'(bus0.Valid_D),    64'(m_valid[0]));
      chk("d0.AdEL_D",     64'(bus0.AdEL_D),     64'(m_adel[0]));
      chk("d0.ExcCode_D",  64'(bus0.ExcCode_D),  64'(m_code[0]));
      chk("d0.BadVAddr_D", 64'(bus0.BadVAddr_D), 64'(m_bad[0]));
      chk("d0.ExcPending", 64'(bus0.ExcPending), 64'(m_pend[0]));
      chk("d0.ExcCount",   64'(bus0.ExcCount),   64'(m_cnt[0]));
      chk("d1.Valid_D",    64'(bus1.Valid_D),    64'(m_valid[1]));
      chk("d1.AdEL_D",     64'(bus1.AdEL_D),     64'(m_adel[1]));
      chk("d1.ExcCode_D",  64'(bus1.ExcCode_D),  64'(m_code[1]));
      chk("d1.BadVAddr_D", 64'(bus1.BadVAddr_D), 64'(m_bad[1]));
      chk("d1.ExcPending", 64'(bus1.ExcPending), 64'(m_pend[1]));
      chk("d1.ExcCount",   64'(bus1.ExcCount),   64'(m_cnt[1]));
   endtask

   // Drive one cycle of stimulus to both instances, clock, predict, check
   task automatic apply(input logic [31:0] a, input bit fv, input bit st, input bit fl);
      bus0.InstrAddr = a; bus0.Fetch_Valid = fv; bus0.Stall_F = st; bus0.Flush = fl;
      bus1.InstrAddr = a; bus1.Fetch_Valid = fv; bus1.Stall_F = st; bus1.Flush = fl;
      @(posedge clk);
      m_clock(a, fv, st, fl);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      m_reset();
      check_all();
      reset = 1'b0;
   endtask

   logic [31:0] pick_list [12];
   logic [31:0] addr;
   int          sel;

   initial begin
      c_r0e[0] = 32'h0000_6FFC; c_r1en[0] = 0; c_cmax[0] = 255;
      c_r0e[1] = 32'h0000_3FFC; c_r1en[1] = 1; c_cmax[1] = 3;
      pick_list = '{32'h2FFC, 32'h3000, 32'h3002, 32'h3FFC, 32'h4000, 32'h417C,
                    32'h4180, 32'h4FFC, 32'h5000, 32'h6FFC, 32'h7000, 32'h7001};

      reset = 1'b1;
      bus0.InstrAddr = '0; bus0.Fetch_Valid = 0; bus0.Stall_F = 0; bus0.Flush = 0;
      bus1.InstrAddr = '0; bus1.Fetch_Valid = 0; bus1.Stall_F = 0; bus1.Flush = 0;
      m_reset();
      @(posedge clk);
      do_reset();

      // In-range boundaries
      apply(32'h3000, 1, 0, 0);
      chk("tp.lo_ok", 64'(bus0.AdEL_D), 64'd0);
      apply(32'h6FFC, 1, 0, 0);
      chk("tp.hi_ok", 64'(bus0.Valid_D), 64'd1);

      // Misaligned fault, then masked younger fault
      apply(32'h3002, 1, 0, 0);
      chk("tp.mis_code", 64'(bus0.ExcCode_D), 64'd4);
      chk("tp.mis_cnt",  64'(bus0.ExcCount),  64'd1);
      apply(32'h7000, 1, 0, 0);
      chk("tp.masked_bad", 64'(bus0.BadVAddr_D), 64'h3002);

      // Flush, then a below-region fault
      apply(32'h7000, 1, 0, 1);
      chk("tp.flush_pend", 64'(bus0.ExcPending), 64'd0);
      apply(32'h2FFC, 1, 0, 0);
      chk("tp.below_cnt", 64'(bus0.ExcCount), 64'd2);
      apply(32'h0, 0, 0, 1);

      // Stall holds everything, release lets the fault in
      for (int i = 0; i < 3; i++) apply(32'h7000, 1, 1, 0);
      apply(32'h7000, 1, 0, 0);
      chk("tp.stall_rel", 64'(bus0.AdEL_D), 64'd1);
      apply(32'h0, 0, 0, 1);

      // Flush beats simultaneous error and stall
      apply(32'h3002, 1, 1, 1);
      chk("tp.flush_win", 64'(bus0.ExcCount), 64'd3);

      // Fetch_Valid low never faults
      apply(32'hFFFF_FFFF, 0, 0, 0);

      // Region 1 start in the two-region instance, then counter saturation
      do_reset();
      apply(32'h4180, 1, 0, 0);
      chk("tp.r1_start", 64'(bus1.AdEL_D), 64'd0);
      for (int i = 0; i < 5; i++) begin
         apply(32'h7000, 1, 0, 0);
         apply(32'h0, 0, 0, 1);
      end
      chk("tp.sat", 64'(bus1.ExcCount), 64'd3);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         sel = int'($urandom_range(0, 2));
         if (sel == 0)      addr = pick_list[$urandom_range(0, 11)];
         else if (sel == 1) addr = 32'h2000 + ($urandom_range(0, 32'h6000) & 32'hFFFF_FFFE);
         else               addr = $urandom;
         apply(addr, ($urandom_range(0, 99) < 85),
                     ($urandom_range(0, 99) < 20),
                     ($urandom_range(0, 99) < 12));
      end

      // Asynchronous reset while a fault is pending
      apply(32'h0, 0, 0, 1);
      apply(32'h7000, 1, 0, 0);
      chk("tp.pend_before_rst", 64'(bus0.ExcPending), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      m_reset();
      check_all();
      #3;
      reset = 1'b0;
      bus0.Fetch_Valid = 0; bus1.Fetch_Valid = 0;
      bus0.Flush = 0; bus1.Flush = 0;
      apply(32'h3000, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/exc_fetch_ctrl.md
Name: exc_fetch_ctrl

Overview:
- Parametrised fetch-stage exception unit.
- Checks each fetch address for misalignment and out-of-range conditions against two independently configurable valid regions.
- Registers the result into the F/D boundary with stall and flush support.
- Tracks a pending fetch exception so that only the oldest one is reported until CP0 flushes the pipe; keeps a saturating event counter for debug.

Parameters:
- ADDR_W, 32, fetch address width
- ALIGN_BITS, 2, low address bits that must be zero (0 disables the alignment check)
- R0_START, 32'h0000_3000, region 0 first valid address (inclusive)
- R0_END, 32'h0000_6FFC, region 0 last valid address (inclusive)
- R1_EN, 0, 1 enables region 1
- R1_START, 32'h0000_4180, region 1 first valid address
- R1_END, 32'h0000_4FFC, region 1 last valid address
- EXC_W, 5, exception code width
- EXC_ADEL, 5'd4, code reported for a fetch address error
- EXC_NONE, 5'd0, code meaning "no exception"
- CNT_W, 8, event counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- InstrAddr  in  ADDR_W  current PC
- Fetch_Valid  in  1  InstrAddr is a real fetch this cycle
- Stall_F  in  1  hold the F/D register
- Flush  in  1  CP0 exception entry or ERET; clears the F/D register and the pending state
- ExcCode_D  out  EXC_W  registered exception code
- AdEL_D  out  1  registered address-error flag
- BadVAddr_D  out  ADDR_W  faulting address, valid when AdEL_D=1
- Valid_D  out  1  registered Fetch_Valid
- ExcPending  out  1  a fetch exception is outstanding
- ExcCount  out  CNT_W  number of accepted fetch exceptions, saturating

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset.
- Detection (combinational):
  - mis = |InstrAddr[ALIGN_BITS-1:0] (0 if ALIGN_BITS=0)
  - in0 = R0_START<=InstrAddr<=R0_END, unsigned compare
  - in1 = R1_EN & (R1_START<=InstrAddr<=R1_END)
  - err = Fetch_Valid & (mis | ~(in0|in1))
- FSM states: RUN, PEND. Reset state is RUN.
  - RUN -> PEND on an accepted error: err=1, Stall_F=0, Flush=0.
  - PEND -> RUN on Flush only.
  - In PEND, err is masked (the accepted value is 0). Younger wrong-path fetches never overwrite the reported exception.
- F/D register update priority:
  1. reset
  2. Flush
  3. Stall_F
  4. load
- Flush:
  - Valid_D=0, AdEL_D=0, ExcCode_D=EXC_NONE, BadVAddr_D=0.
  - State -> RUN.
  - Flush wins over a simultaneous err and Stall_F; that error is not accepted and not counted.
- Stall_F=1 (no Flush): all D outputs and state hold; err is ignored that cycle.
- Load:
  - Valid_D <= Fetch_Valid
  - AdEL_D <= accepted err
  - ExcCode_D <= accepted err ? EXC_ADEL : EXC_NONE
  - BadVAddr_D <= accepted err ? InstrAddr : BadVAddr_D (holds the last fault)
- Latency: one cycle from InstrAddr to the D outputs.
- ExcPending = (state==PEND), registered, so it asserts the same edge AdEL_D asserts.
- ExcCount:
  - Increments by 1 on each accepted error.
  - Saturates at all-ones; no wrap.
  - Cleared only by reset; Flush does not clear it.
- Boundaries:
  - An address equal to R0_END or R1_START is valid (inclusive).
  - A misaligned address inside a region still errors.
  - Fetch_Valid=0 never errors, regardless of address.
- Reset values: ExcCode_D=EXC_NONE, AdEL_D=0, BadVAddr_D=0, Valid_D=0, ExcPending=0, ExcCount=0, state RUN. Reset mid-PEND returns to RUN immediately, asynchronously.

Test Plan:
- Defaults; InstrAddr=0x3000, then 0x6FFC, Fetch_Valid=1 -> AdEL_D=0, ExcCode_D=0, Valid_D=1 one cycle after each address.
- InstrAddr=0x3002 -> next cycle AdEL_D=1, ExcCode_D=4, BadVAddr_D=0x3002, ExcPending=1, ExcCount=1. Then InstrAddr=0x7000 with no Flush -> AdEL_D=0, BadVAddr_D stays 0x3002, ExcCount stays 1.
- In PEND, assert Flush -> next cycle Valid_D=0, ExcPending=0. Then 0x2FFC -> AdEL_D=1, ExcCount=2.
- InstrAddr=0x7000 with Stall_F=1 for 3 cycles -> outputs unchanged, ExcCount unchanged. Release the stall -> AdEL_D=1 next cycle.
- Same cycle err=1, Stall_F=1, Flush=1 -> D cleared, state RUN, ExcCount unchanged.
- CNT_W=2, R1_EN=1 with R0_END=0x3FFC, address 0x4180 -> no error. Then five errors, each followed by Flush -> ExcCount = 1, 2, 3, 3, 3. Assert reset mid-PEND -> all outputs return to reset values asynchronously.
